// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// data word width and default geometry.
package cpu_pkg;

   localparam int WORD_W     = 32;
   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DEPTH  = 512;
   localparam int MAX_WAIT   = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Wait counter load value; the counter expires on zero, so it starts at cycles-1.
   function automatic logic [3:0] wait_load(input int cycles);
      int c;
      c = (cycles > MAX_WAIT) ? MAX_WAIT : cycles;
      if (c <= 0) return 4'd0;
      return 4'(c - 1);
   endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with registered read and write enable.
// Storage is never reset; only the read register clears on reset.
module ram_sp
   import cpu_pkg::*;
#(
   parameter int    ADDR_W    = DEF_ADDR_W,
   parameter int    DEPTH     = DEF_DEPTH,
   parameter string INIT_FILE = ""
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] q
);

   localparam bit ADDR_POW2 = (DEPTH == (1 << ADDR_W));

   logic [WORD_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] idx;

   // Non-power-of-two depths fold the address space back onto the array.
   always_comb begin
      idx = addr;
      if (!ADDR_POW2) idx = ADDR_W'(32'(addr) % DEPTH);
   end

   always_ff @(posedge clock) begin
      if (we) mem[idx] <= wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= '0;
      else if (re) q <= mem[idx];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write from the control unit, waits
// WAIT_CYCLES, performs the access on ram_sp and pulses mem_ready.
//
// state     | meaning
// ST_IDLE   | waiting for exactly one of MD_read / Write
// ST_WAIT   | counting down wait cycles before the access
// ST_ACCESS | RAM strobed with latched address/data/op
// ST_DONE   | result delivered; hold until both requests drop
module mem_responder
   import cpu_pkg::*;
#(
   parameter int    ADDR_W      = DEF_ADDR_W,
   parameter int    DEPTH       = DEF_DEPTH,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MD_read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] MAR_addr,
   input  logic [WORD_W-1:0] MDR_data,
   output logic [WORD_W-1:0] Mdatain,
   output logic              mem_ready,
   output logic              mem_busy,
   output logic              mem_err
);

   localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] data_q;
   logic              pending;
   logic              pending_rd;
   logic              ram_we;
   logic              ram_re;
   logic [WORD_W-1:0] ram_q;

   // The RAM op commits on the single edge that leaves ACCESS, so a reset can
   // never split a write: the word is either untouched or fully written.
   assign ram_we = (state == ST_ACCESS) &&  op_write;
   assign ram_re = (state == ST_ACCESS) && !op_write;

   ram_sp #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .INIT_FILE(INIT_FILE)
   ) u_ram (
      .clock(clock),
      .reset(reset),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q),
      .wdata(data_q),
      .q    (ram_q)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         op_write   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         pending    <= 1'b0;
         pending_rd <= 1'b0;
         Mdatain    <= '0;
         mem_ready  <= 1'b0;
         mem_busy   <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         mem_ready <= pending;
         mem_err   <= 1'b0;
         pending   <= 1'b0;
         // RAM read data is registered, so the result is picked up one edge after ACCESS.
         if (pending && pending_rd) Mdatain <= ram_q;

         unique case (state)
            ST_IDLE: begin
               if (MD_read && Write) begin
                  mem_err  <= 1'b1;
                  mem_busy <= 1'b1;
                  state    <= ST_DONE;
               end else if (MD_read || Write) begin
                  addr_q   <= MAR_addr;
                  data_q   <= MDR_data;
                  op_write <= Write;
                  mem_busy <= 1'b1;
                  if (WAIT_CYCLES > 0) begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= ST_WAIT;
                  end else begin
                     state <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) state <= ST_ACCESS;
               else wait_cnt <= wait_cnt - 4'd1;
            end
            ST_ACCESS: begin
               pending    <= 1'b1;
               pending_rd <= !op_write;
               state      <= ST_DONE;
            end
            ST_DONE: begin
               if (!MD_read && !Write) begin
                  mem_busy <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               mem_busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3 for latency and reset-during-wait scenarios.
module tb_mem_responder;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, md_read, write;
   logic [8:0]  addr;
   logic [31:0] wdata, mdatain;
   logic        mem_ready, mem_busy, mem_err;

   logic        reset3, md_read3, write3;
   logic [8:0]  addr3;
   logic [31:0] wdata3, mdatain3;
   logic        mem_ready3, mem_busy3, mem_err3;

   int checks   = 0;
   int failures = 0;

   mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) dut (
      .clock(clock), .reset(reset), .MD_read(md_read), .Write(write),
      .MAR_addr(addr), .MDR_data(wdata), .Mdatain(mdatain),
      .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err));

   mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(3)) dut3 (
      .clock(clock), .reset(reset3), .MD_read(md_read3), .Write(write3),
      .MAR_addr(addr3), .MDR_data(wdata3), .Mdatain(mdatain3),
      .mem_ready(mem_ready3), .mem_busy(mem_busy3), .mem_err(mem_err3));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d);
      if (sel) begin
         md_read3 = rd; write3 = wr; addr3 = a; wdata3 = d;
      end else begin
         md_read = rd; write = wr; addr = a; wdata = d;
      end
   endtask

   // Applies a request held for 'hold' edges (edge 0 = acceptance) and records
   // what the outputs did; the calling test compares the results.
   task automatic do_req(input bit sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d, input int hold,
                         input bit chg, input logic [8:0] a2, input logic [31:0] d2,
                         output int ready_edge, output int ready_cnt, output int err_cnt,
                         output logic [31:0] rd_val, output int busy_low_held,
                         output logic busy_after, output logic busy_end);
      logic rdy, bsy, er;
      ready_edge = -1; ready_cnt = 0; err_cnt = 0; rd_val = 'x;
      busy_low_held = 0; busy_after = 1'bx; busy_end = 1'bx;
      drive(sel, rd, wr, a, d);
      for (int i = 0; i < hold + 8; i++) begin
         tick();
         rdy = sel ? mem_ready3 : mem_ready;
         bsy = sel ? mem_busy3  : mem_busy;
         er  = sel ? mem_err3   : mem_err;
         if (rdy) begin
            ready_cnt++;
            if (ready_edge < 0) begin
               ready_edge = i;
               rd_val = sel ? mdatain3 : mdatain;
            end
         end
         if (er) err_cnt++;
         if (i < hold && !bsy) busy_low_held++;
         if (i == hold) busy_after = bsy;
         busy_end = bsy;
         if (i == 0 && chg) drive(sel, rd, wr, a2, d2);
         if (i == hold - 1) drive(sel, 1'b0, 1'b0, chg ? a2 : a, chg ? d2 : d);
      end
   endtask

   task automatic test_reset();
      int rdy_seen = 0, busy_seen = 0;
      reset = 1'b1; reset3 = 1'b1;
      drive(0, 0, 0, 9'h000, 32'h0);
      drive(1, 0, 0, 9'h000, 32'h0);
      tick(); tick();
      reset = 1'b0; reset3 = 1'b0;
      checks++; if (mdatain !== 32'h0) begin failures++; $display("FAIL reset_mdatain got=%h exp=00000000", mdatain); end
      checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
      checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_err); end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_ready !== 1'b0) rdy_seen++;
         if (mem_busy !== 1'b0) busy_seen++;
      end
      checks++; if (rdy_seen != 0) begin failures++; $display("FAIL idle_ready_pulses got=%0d exp=0", rdy_seen); end
      checks++; if (busy_seen != 0) begin failures++; $display("FAIL idle_busy_cycles got=%0d exp=0", busy_seen); end
      checks++; if (mdatain !== 32'h0) begin failures++; $display("FAIL idle_mdatain got=%h exp=00000000", mdatain); end
   endtask

   task automatic test_write();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      do_req(0, 0, 1, 9'h054, 32'h0000_00A7, 6, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (re != 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", re); end
      checks++; if (rc != 1) begin failures++; $display("FAIL wr_ready_count got=%0d exp=1", rc); end
      checks++; if (ec != 0) begin failures++; $display("FAIL wr_err_count got=%0d exp=0", ec); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL wr_idle_after_drop got=%b exp=0", ba); end
      checks++; if (mdatain !== 32'h0) begin failures++; $display("FAIL wr_mdatain_unchanged got=%h exp=00000000", mdatain); end
   endtask

   task automatic test_read();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      // Request dropped before DONE: must still complete.
      do_req(0, 1, 0, 9'h054, 32'h0, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (re != 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", re); end
      checks++; if (rv !== 32'h0000_00A7) begin failures++; $display("FAIL rd_data got=%h exp=000000a7", rv); end
      checks++; if (rc != 1) begin failures++; $display("FAIL rd_ready_count got=%0d exp=1", rc); end
      checks++; if (be !== 1'b0) begin failures++; $display("FAIL rd_busy_end got=%b exp=0", be); end
   endtask

   task automatic test_held_read();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      do_req(0, 1, 0, 9'h054, 32'h0, 10, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (rc != 1) begin failures++; $display("FAIL held_ready_count got=%0d exp=1", rc); end
      checks++; if (bl != 0) begin failures++; $display("FAIL held_busy_low_cycles got=%0d exp=0", bl); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL held_busy_after_drop got=%b exp=0", ba); end
      checks++; if (rv !== 32'h0000_00A7) begin failures++; $display("FAIL held_data got=%h exp=000000a7", rv); end
   endtask

   task automatic test_conflict();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      do_req(0, 0, 1, 9'h077, 32'hDEAD_BEEF, 3, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      do_req(0, 1, 1, 9'h077, 32'h5555_5555, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (ec != 1) begin failures++; $display("FAIL conflict_err_count got=%0d exp=1", ec); end
      checks++; if (rc != 0) begin failures++; $display("FAIL conflict_ready_count got=%0d exp=0", rc); end
      checks++; if (be !== 1'b0) begin failures++; $display("FAIL conflict_busy_end got=%b exp=0", be); end
      checks++; if (mdatain !== 32'h0000_00A7) begin failures++; $display("FAIL conflict_mdatain got=%h exp=000000a7", mdatain); end
      do_req(0, 1, 0, 9'h077, 32'h0, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (rv !== 32'hDEAD_BEEF) begin failures++; $display("FAIL conflict_word_kept got=%h exp=deadbeef", rv); end
   endtask

   task automatic test_addr_change();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      do_req(0, 0, 1, 9'h000, 32'h0000_0C0C, 3, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      do_req(0, 0, 1, 9'h1FF, 32'h0BAD_F00D, 4, 1, 9'h000, 32'h1111_1111, re, rc, ec, rv, bl, ba, be);
      checks++; if (rc != 1) begin failures++; $display("FAIL chg_ready_count got=%0d exp=1", rc); end
      do_req(0, 1, 0, 9'h1FF, 32'h0, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (rv !== 32'h0BAD_F00D) begin failures++; $display("FAIL chg_word_1ff got=%h exp=0badf00d", rv); end
      do_req(0, 1, 0, 9'h000, 32'h0, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (rv !== 32'h0000_0C0C) begin failures++; $display("FAIL chg_word_000 got=%h exp=00000c0c", rv); end
   endtask

   task automatic test_reset_in_wait();
      int re, rc, ec, bl; logic [31:0] rv; logic ba, be;
      int rdy_seen = 0;
      do_req(1, 0, 1, 9'h010, 32'h0000_1234, 7, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (re != 5) begin failures++; $display("FAIL w3_latency got=%0d exp=5", re); end
      drive(1, 0, 1, 9'h010, 32'h0000_9999);
      tick();
      tick();
      checks++; if (mem_busy3 !== 1'b1) begin failures++; $display("FAIL w3_busy_in_wait got=%b exp=1", mem_busy3); end
      reset3 = 1'b1;
      #1;
      checks++; if (mem_busy3 !== 1'b0) begin failures++; $display("FAIL w3_busy_on_reset got=%b exp=0", mem_busy3); end
      drive(1, 0, 0, 9'h010, 32'h0);
      tick();
      reset3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (mem_ready3 !== 1'b0) rdy_seen++;
      end
      checks++; if (rdy_seen != 0) begin failures++; $display("FAIL w3_ready_after_abort got=%0d exp=0", rdy_seen); end
      do_req(1, 1, 0, 9'h010, 32'h0, 2, 0, 9'h0, 32'h0, re, rc, ec, rv, bl, ba, be);
      checks++; if (rv !== 32'h0000_1234) begin failures++; $display("FAIL w3_word_kept got=%h exp=00001234", rv); end
      checks++; if (re != 5) begin failures++; $display("FAIL r3_latency got=%0d exp=5", re); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_held_read();
      test_conflict();
      test_addr_change();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, word-address width; DEPTH, default 512, words of storage; WAIT_CYCLES, default 1, extra wait cycles (0..15) before access.
REQ-002 Ports SHALL be, in order: clock in 1 system clock; reset in 1 async active-high reset; MD_read in 1 read request from control unit; Write in 1 write request from control unit; MAR_addr in ADDR_W word address; MDR_data in 32 write data; Mdatain out 32 read data to MDR mux; mem_ready out 1 one-cycle completion pulse; mem_busy out 1 request in service; mem_err out 1 one-cycle pulse on conflicting request.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; all flops SHALL be rising-edge `clock`, cleared on `posedge reset`.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT, ACCESS, DONE; encoding SHALL come from the shared package.
REQ-005 IDLE: if exactly one of MD_read/Write is high, the block SHALL latch MAR_addr, MDR_data and op, and go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
REQ-006 IDLE with MD_read and Write both high SHALL pulse mem_err for one cycle, perform no access, and go to DONE.
REQ-007 WAIT SHALL decrement a 4-bit counter loaded with WAIT_CYCLES-1 on entry and go to ACCESS when the counter is zero.
REQ-008 ACCESS write SHALL store the latched data at the latched address; ACCESS read SHALL load Mdatain from the latched address; both SHALL pulse mem_ready one cycle after ACCESS and go to DONE.
REQ-009 Latency SHALL be WAIT_CYCLES+2 rising edges from the acceptance edge to mem_ready high.
REQ-010 DONE SHALL hold until both MD_read and Write are low, then return to IDLE. A request held high SHALL NOT be serviced twice.
REQ-011 Mdatain SHALL keep its last read value until the next read completes. Writes SHALL NOT change Mdatain.
REQ-012 mem_busy SHALL be high in WAIT, ACCESS and DONE, and low in IDLE.
REQ-013 Changes on MAR_addr/MDR_data after acceptance SHALL have no effect on the access in progress.
REQ-014 Addresses SHALL wrap modulo DEPTH. With DEPTH = 2^ADDR_W every address is valid.
REQ-015 A request dropped before DONE SHALL still complete. The block SHALL then return from DONE to IDLE on the next edge.

Reset
REQ-016 Reset SHALL force the state to IDLE, Mdatain=0, mem_ready=0, mem_busy=0, mem_err=0 and the wait counter to 0.
REQ-017 Reset SHALL NOT clear storage contents.
REQ-018 Reset asserted in WAIT SHALL abort the access, and no write SHALL be committed.
REQ-019 Reset asserted during ACCESS SHALL leave the target word either fully old or fully new.
REQ-020 After reset release, the first rising edge SHALL evaluate IDLE.

Structure
REQ-021 Package cpu_pkg SHALL hold the FSM state typedef/constants, the 32-bit word width constant, and the default ADDR_W/DEPTH.
REQ-022 Storage SHALL be one sub-module, ram_sp (single-port synchronous RAM, registered read, write-enable). The FSM and counter SHALL live in mem_responder.
REQ-023 Storage SHALL be preloadable from a hex file via an optional parameter INIT_FILE, empty by default.

Verification
REQ-024 Reset then idle: Mdatain=0, mem_busy=0, mem_ready never pulses across 20 cycles.
REQ-025 WAIT_CYCLES=1: Write=1, MAR_addr=0x054, MDR_data=0x0000_00A7, held -> mem_ready pulses once at edge 3. Write drops -> IDLE. MD_read at 0x054 -> Mdatain=0x0000_00A7 when mem_ready pulses.
REQ-026 MD_read and Write high together in IDLE -> mem_err pulses one cycle, no mem_ready, and the storage word at MAR_addr is unchanged.
REQ-027 MD_read held 10 cycles at 0x054 -> exactly one mem_ready pulse, and mem_busy stays high until MD_read drops.
REQ-028 Write to 0x1FF accepted, MAR_addr changed to 0x000 the next cycle -> data lands at 0x1FF only.
REQ-029 WAIT_CYCLES=3: reset asserted in WAIT during a write to 0x010 (old value 0x1234) -> the block returns to IDLE, and a later read of 0x010 returns 0x1234.
